lcd_16x2_refresh: RTL and testbench



---
 rtl/lcd_16x2_refresh.sv | 186 ++++++++++++++++++
 tb/tb_lcd_16x2_refresh.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_16x2_refresh.sv
// HD44780 16x2 refresh engine: power-up wait, four init commands, then continuous
// 34-write frames (line-address command + 16 characters per line) read from a character ROM.
module lcd_16x2_refresh #(
    parameter int unsigned POWERUP_CYC = 2000000,
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned E_CYC       = 50,
    parameter int unsigned WAIT_CYC    = 5000,
    parameter int unsigned CLEAR_CYC   = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] char_code,
    output logic [7:0] char_xy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       ready,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        ST_PWR   = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_EHIGH = 3'd3,
        ST_WAIT  = 3'd4,
        ST_IDLE  = 3'd5
    } state_t;

    localparam logic [23:0] PWR_LD   = 24'(POWERUP_CYC - 1);
    localparam logic [23:0] SETUP_LD = 24'(SETUP_CYC - 1);
    localparam logic [23:0] E_LD     = 24'(E_CYC - 1);
    localparam logic [23:0] WAIT_LD  = 24'(WAIT_CYC - 1);
    localparam logic [23:0] CLEAR_LD = 24'(CLEAR_CYC - 1);

    localparam logic [5:0] LAST_INIT_TX  = 6'd3;
    localparam logic [5:0] LINE1_TX      = 6'd17;
    localparam logic [5:0] LAST_FRAME_TX = 6'd33;

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [5:0]  seq_q, seq_d;
    logic [4:0]  xy_q, xy_d;
    logic        rs_q, rs_d;
    logic [7:0]  data_q, data_d;
    logic        e_q, e_d;
    logic        ready_q, ready_d;

    logic        tx_rs;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic        cnt_zero;
    logic [23:0] wait_ld;

    // seq_q indexes the init command list until ready, then the 34 frame writes.
    always_comb begin
        tx_rs   = 1'b0;
        tx_data = 8'h00;
        if (!ready_q) begin
            case (seq_q[1:0])
                2'd0:    tx_data = 8'h38;
                2'd1:    tx_data = 8'h0C;
                2'd2:    tx_data = 8'h06;
                default: tx_data = 8'h01;
            endcase
        end else if (seq_q == 6'd0) begin
            tx_data = 8'h80;
        end else if (seq_q == LINE1_TX) begin
            tx_data = 8'hC0;
        end else begin
            tx_rs   = 1'b1;
            tx_data = {1'b0, char_code};
        end
    end

    assign tx_last  = ready_q ? (seq_q == LAST_FRAME_TX) : (seq_q == LAST_INIT_TX);
    assign cnt_zero = (cnt_q == 24'd0);
    assign wait_ld  = (!rs_q && data_q == 8'h01) ? CLEAR_LD : WAIT_LD;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seq_d   = seq_q;
        xy_d    = xy_q;
        rs_d    = rs_q;
        data_d  = data_q;
        ready_d = ready_q;
        case (state_q)
            ST_PWR: begin
                if (cnt_zero) begin
                    state_d = ST_LOAD;
                    seq_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            ST_LOAD: begin
                rs_d    = tx_rs;
                data_d  = tx_data;
                state_d = ST_SETUP;
                cnt_d   = SETUP_LD;
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_d = ST_EHIGH;
                    cnt_d   = E_LD;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            ST_EHIGH: begin
                if (cnt_zero) begin
                    state_d = ST_WAIT;
                    cnt_d   = wait_ld;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    // Advance the ROM address one cycle ahead of the next LOAD; 5-bit wrap gives 0x1F->0x00.
                    if (ready_q && rs_q) begin
                        xy_d = xy_q + 5'd1;
                    end
                    if (tx_last) begin
                        seq_d = 6'd0;
                        if (!ready_q) begin
                            ready_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = enable ? ST_LOAD : ST_IDLE;
                        end
                    end else begin
                        seq_d   = seq_q + 6'd1;
                        state_d = ST_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_PWR;
                cnt_d   = PWR_LD;
            end
        endcase
        e_d = (state_d == ST_EHIGH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_PWR;
            cnt_q   <= PWR_LD;
            seq_q   <= 6'd0;
            xy_q    <= 5'd0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            e_q     <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            xy_q    <= xy_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            e_q     <= e_d;
            ready_q <= ready_d;
        end
    end

    assign char_xy    = {3'b000, xy_q};
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_e      = e_q;
    assign lcd_data   = data_q;
    assign ready      = ready_q;
    assign frame_done = ready_q && (state_q == ST_WAIT) && cnt_zero && (seq_q == LAST_FRAME_TX);

endmodule

// File: tb/tb_lcd_16x2_refresh.sv
// Bench for lcd_16x2_refresh: a schedule model predicts every LCD write (cycle, address,
// rs, data) and every frame_done; a monitor matches what the DUT actually drives.
module tb_lcd_16x2_refresh;

  localparam int POWERUP = 20;
  localparam int SETUP   = 2;
  localparam int E       = 3;
  localparam int WAIT    = 5;
  localparam int CLEAR   = 10;
  localparam int TX      = 1 + SETUP + E + WAIT;
  localparam int FRAME   = 34 * TX;
  localparam int W       = 49;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [6:0] char_code;
  logic [7:0] char_xy;
  logic       lcd_rs, lcd_rw, lcd_e, ready, frame_done;
  logic [7:0] lcd_data;

  lcd_16x2_refresh #(
    .POWERUP_CYC(POWERUP), .SETUP_CYC(SETUP), .E_CYC(E), .WAIT_CYC(WAIT), .CLEAR_CYC(CLEAR)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .char_code(char_code), .char_xy(char_xy),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data),
    .ready(ready), .frame_done(frame_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- ROM model with optional garbling ----------------
  logic [6:0] rom [32];
  logic       garble = 1'b0;
  logic [6:0] gval = 7'd0;
  int         g_start = 0;
  int         g_end = 0;

  assign char_code = garble ? gval : rom[char_xy[4:0]];

  always @(posedge clk) begin
    #1;
    if (cyc >= g_start && cyc < g_end && ((cyc - g_start) % TX) != 0) begin
      garble = 1'b1;
      gval   = 7'($urandom_range(0, 127));
    end else begin
      garble = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [31:0]  fd_q[$];
  int checks = 0;
  int passed = 0;
  int exp_ready = -1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endfunction

  function automatic void fail_event(input string name);
    checks++;
    $display("FAIL %s: got an event, expected none at cycle %0d", name, cyc);
  endfunction

  task automatic push_tx(input int load_c, input logic [7:0] xy, input logic rs, input logic [7:0] d);
    exp_q.push_back({32'(load_c + 1 + SETUP), xy, rs, d});
  endtask

  task automatic push_init(input int rel);
    logic [7:0] cmds [4];
    int t;
    cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
    t = rel + POWERUP;
    for (int i = 0; i < 4; i++) begin
      push_tx(t, 8'h00, 1'b0, cmds[i]);
      t += 1 + SETUP + E + ((cmds[i] == 8'h01) ? CLEAR : WAIT);
    end
    exp_ready = t;
  endtask

  task automatic push_frame(input int s);
    int t;
    t = s;
    for (int line = 0; line < 2; line++) begin
      push_tx(t, 8'(line * 16), 1'b0, (line == 0) ? 8'h80 : 8'hC0);
      t += TX;
      for (int col = 0; col < 16; col++) begin
        push_tx(t, 8'(line * 16 + col), 1'b1, {1'b0, rom[line * 16 + col]});
        t += TX;
      end
    end
    fd_q.push_back(32'(s + FRAME - 1));
  endtask

  // ---------------- monitor ----------------
  logic       prev_e = 1'b0, prev_ready = 1'b0;
  logic [8:0] hist1 = 9'd0, hist2 = 9'd0, cur_v = 9'd0, v;
  logic       in_win = 1'b0, stable_ok = 1'b1, have_win = 1'b0;
  int         rise_c = 0, win_end = 0;
  logic [W-1:0] ent;

  always @(negedge clk) begin
    if (reset) begin
      prev_e = 1'b0;
      prev_ready = 1'b0;
      in_win = 1'b0;
      have_win = 1'b0;
    end else begin
      v = {lcd_rs, lcd_data};
      if (lcd_e && !prev_e) begin
        if (have_win) check("data_stable", {63'd0, stable_ok}, 64'd1);
        check("setup_stable", {63'd0, (hist1 == v && hist2 == v)}, 64'd1);
        check("lcd_rw", {63'd0, lcd_rw}, 64'd0);
        if (exp_q.size() == 0) begin
          fail_event("unexpected_e_pulse");
        end else begin
          ent = exp_q.pop_front();
          check("e_rise_cycle", 64'(cyc), 64'(ent[48:17]));
          check("char_xy", 64'(char_xy), 64'(ent[16:9]));
          check("rs_data", 64'(v), 64'(ent[8:0]));
        end
        rise_c = cyc;
        cur_v = v;
        stable_ok = 1'b1;
        in_win = 1'b1;
        have_win = 1'b1;
        win_end = cyc + E + ((v == 9'h001) ? CLEAR : WAIT) - 1;
      end else if (in_win) begin
        if (v != cur_v) stable_ok = 1'b0;
        if (cyc >= win_end) in_win = 1'b0;
      end
      if (!lcd_e && prev_e) check("e_width", 64'(cyc - rise_c), 64'(E));
      if (ready && !prev_ready) check("ready_cycle", 64'(cyc), 64'(exp_ready));
      if (frame_done) begin
        if (fd_q.size() == 0) fail_event("unexpected_frame_done");
        else check("frame_done_cycle", 64'(cyc), 64'(fd_q.pop_front()));
      end
      prev_e = lcd_e;
      prev_ready = ready;
      hist2 = hist1;
      hist1 = v;
    end
  end

  // ---------------- driver ----------------
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_char_xy", 64'(char_xy), 64'd0);
    check("rst_lcd_rs", 64'(lcd_rs), 64'd0);
    check("rst_lcd_rw", 64'(lcd_rw), 64'd0);
    check("rst_lcd_e", 64'(lcd_e), 64'd0);
    check("rst_lcd_data", 64'(lcd_data), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
  endtask

  task automatic randomize_rom();
    for (int i = 0; i < 32; i++) rom[i] = 7'($urandom_range(32, 126));
  endtask

  initial begin
    string line0, line1;
    int rel0, rel1, s0, s3;
    line0 = "   DIFFICULTY:  ";
    line1 = "      HARD      ";
    for (int i = 0; i < 16; i++) begin
      rom[i]      = 7'(line0[i]);
      rom[i + 16] = 7'(line1[i]);
    end

    // Power-up and init with enable low; no frame may start.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    rel0 = cyc;
    push_init(rel0);
    wait_until(rel0 + 100);
    check("init_all_seen", 64'(exp_q.size()), 64'd0);

    // Three back-to-back frames; the last two with char_code garbled outside LOAD.
    enable = 1'b1;
    s0 = cyc + 1;
    for (int f = 0; f < 3; f++) push_frame(s0 + f * FRAME);
    g_start = s0 + FRAME;
    g_end   = s0 + 3 * FRAME;

    // Drop enable mid-frame: the frame still completes, then the block idles.
    wait_until(s0 + 2 * FRAME + 100);
    enable = 1'b0;
    wait_until(s0 + 3 * FRAME + 6);
    check("idle_e_low", 64'(lcd_e), 64'd0);
    check("idle_no_pending", 64'(exp_q.size()), 64'd0);

    // New ROM content, restart, then reset while E is high during char 0x07.
    randomize_rom();
    enable = 1'b1;
    s3 = cyc + 1;
    push_frame(s3);
    wait_until(s3 + 8 * TX + 1 + SETUP + 1);
    check("e_high_before_reset", 64'(lcd_e), 64'd1);
    reset = 1'b1;
    wait_until(cyc + 1);
    check_reset_outputs();
    exp_q.delete();
    fd_q.delete();

    // Full init repeats, then one more frame with fresh ROM content.
    randomize_rom();
    reset = 1'b0;
    rel1 = cyc;
    push_init(rel1);
    push_frame(rel1 + 70);
    wait_until(rel1 + 70 + 100);
    enable = 1'b0;
    wait_until(rel1 + 70 + FRAME + 20);
    check("final_e_low", 64'(lcd_e), 64'd0);
    check("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("final_fd_q_empty", 64'(fd_q.size()), 64'd0);
    if (have_win) check("data_stable", {63'd0, stable_ok}, 64'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
